// File: rtl/uart_tx_block_if.sv
// Load handshake and serial-line bundle for the UART transmitter.
// The master side is the byte producer; the slave side is uart_tx_block.
interface uart_tx_block_if #(
    parameter int NUM_DATA_BITS   = 8,
    parameter int NUM_PERIOD_BITS = 14
);
    logic                       load_en;
    logic [NUM_DATA_BITS-1:0]   tx_data;
    logic [NUM_PERIOD_BITS-1:0] bit_period;
    logic                       parity_en;
    logic                       serial_out;
    logic                       tx_busy;
    logic                       tx_done;

    modport master (
        output load_en, tx_data, bit_period, parity_en,
        input  serial_out, tx_busy, tx_done
    );

    modport slave (
        input  load_en, tx_data, bit_period, parity_en,
        output serial_out, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, NUM_DATA_BITS data bits LSB first, optional
// even parity, one stop bit. Every bit lasts bit_period clocks (0 acts as 1).
// All outputs come straight from flops.
module uart_tx_block #(
    parameter int NUM_DATA_BITS   = 8,
    parameter int NUM_PERIOD_BITS = 14
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_block_if.slave  tx_if
);
    localparam int IDX_W = $clog2(NUM_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                     state_q;
    logic [NUM_PERIOD_BITS-1:0] cnt_q;
    logic [NUM_PERIOD_BITS-1:0] cnt_d;
    logic [NUM_PERIOD_BITS-1:0] period_q;
    logic [NUM_PERIOD_BITS-1:0] last_cnt;
    logic [NUM_DATA_BITS-1:0]   shift_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       par_en_q;
    logic                       par_bit_q;
    logic                       serial_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       bit_end;

    // Bit timing: cnt_q counts completed cycles of the current bit; the bit
    // ends when it reaches P-1, with P=0 folded onto P=1.
    always_comb begin
        last_cnt = '0;
        if (period_q != '0) begin
            last_cnt = period_q - NUM_PERIOD_BITS'(1);
        end
        bit_end = (cnt_q == last_cnt);
        cnt_d   = bit_end ? '0 : cnt_q + NUM_PERIOD_BITS'(1);
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q   <= 1'b0;
                    cnt_q    <= '0;
                    serial_q <= 1'b1;
                    if (tx_if.load_en) begin
                        period_q  <= tx_if.bit_period;
                        shift_q   <= tx_if.tx_data;
                        par_en_q  <= tx_if.parity_en;
                        par_bit_q <= ^tx_if.tx_data;
                        idx_q     <= '0;
                        serial_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        idx_q    <= '0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (idx_q == IDX_W'(NUM_DATA_BITS - 1)) begin
                            if (par_en_q) begin
                                serial_q <= par_bit_q;
                                state_q  <= PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= STOP;
                            end
                        end else begin
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            idx_q    <= idx_q + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        serial_q <= 1'b1;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        cnt_q    <= '0;
                        serial_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    cnt_q    <= '0;
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_if.serial_out = serial_q;
    assign tx_if.tx_busy    = busy_q;
    assign tx_if.tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: directed and random frames compared cycle by
// cycle with an expected line waveform built from the frame format.
module tb_uart_tx_block;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    uart_tx_block_if #(.NUM_DATA_BITS(8), .NUM_PERIOD_BITS(14)) bus ();

    uart_tx_block #(.NUM_DATA_BITS(8), .NUM_PERIOD_BITS(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [2:0] line_state();
        return {bus.serial_out, bus.tx_busy, bus.tx_done};
    endfunction

    // Starts a frame in the current (negedge) cycle and follows it; limit=0
    // follows it through the tx_done cycle, otherwise stops after limit cycles.
    task automatic send_frame(input logic [7:0] data, input int per, input bit par,
                              input bit noise, input int limit);
        bit q[$];
        int p;
        int n;
        p = (per == 0) ? 1 : per;
        repeat (p) q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (p) q.push_back(data[i]);
        if (par) repeat (p) q.push_back(^data);
        repeat (p) q.push_back(1'b1);
        n = (limit == 0 || limit > q.size()) ? q.size() : limit;

        bus.load_en    = 1'b1;
        bus.tx_data    = data;
        bus.bit_period = per[13:0];
        bus.parity_en  = par;
        @(posedge clk);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_val("frame", 32'(line_state()), 32'({q[j], 1'b1, 1'b0}));
            if (noise) begin
                bus.load_en    = 1'($urandom_range(0, 1));
                bus.tx_data    = 8'($urandom);
                bus.bit_period = 14'($urandom_range(0, 7));
                bus.parity_en  = 1'($urandom_range(0, 1));
            end else begin
                bus.load_en = 1'b0;
            end
        end
        if (limit == 0) begin
            @(negedge clk);
            check_val("done", 32'(line_state()), 32'(3'b101));
        end
        bus.load_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_val("idle", 32'(line_state()), 32'(3'b100));
        end
    endtask

    // Asynchronous reset in the middle of a cycle, then release.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_val("rst_async", 32'(line_state()), 32'(3'b100));
        @(negedge clk);
        check_val("rst_hold", 32'(line_state()), 32'(3'b100));
        rst = 1'b0;
        idle_cycles(20);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.load_en    = 1'b0;
        bus.tx_data    = 8'h00;
        bus.bit_period = 14'd0;
        bus.parity_en  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_state", 32'(line_state()), 32'(3'b100));
        rst = 1'b0;
        idle_cycles(3);

        // Basic frame with mid-frame load pulses and input changes.
        send_frame(8'hA5, 4, 1'b0, 1'b1, 0);
        idle_cycles(2);
        // Even parity, odd and even number of ones.
        send_frame(8'h07, 2, 1'b1, 1'b0, 0);
        idle_cycles(1);
        send_frame(8'h03, 2, 1'b1, 1'b0, 0);
        idle_cycles(1);
        // Minimum periods, then back-to-back loads in the tx_done cycle.
        send_frame(8'hFF, 0, 1'b0, 1'b0, 0);
        send_frame(8'hFF, 1, 1'b0, 1'b0, 0);
        send_frame(8'h3C, 3, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // Reset in the middle of the data bits: no done, line held high.
        send_frame(8'hA5, 4, 1'b0, 1'b0, 18);
        pulse_reset();

        // Random frames, some back-to-back, some with idle gaps.
        for (int k = 0; k < 14; k++) begin
            send_frame(8'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0);
            idle_cycles($urandom_range(0, 2));
        end

        // Longest period: start bit and first data bit at full length.
        send_frame(8'h81, 16383, 1'b0, 1'b0, 2 * 16383 + 10);
        pulse_reset();
        send_frame(8'h5A, 1, 1'b1, 1'b0, 0);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
Serial transmitter that is the sending end of the team's UART link. It accepts a parallel byte through a load handshake and shifts out one frame: start bit, data LSB first, optional even parity, one stop bit. Bit timing comes from an internal programmable bit-period counter with clear, enable and rollover behaviour. It pairs with the existing receive path, which recovers the same frame format.

Parameters:
NUM_DATA_BITS, 8, data bits per frame (legal range 5..9)
NUM_PERIOD_BITS, 14, width of bit_period and of the internal bit-timing counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
load_en  input  1  request to transmit tx_data; accepted only when tx_busy=0
tx_data  input  NUM_DATA_BITS  byte to send, sampled on an accepted load
bit_period  input  NUM_PERIOD_BITS  clk cycles per serial bit, sampled on an accepted load
parity_en  input  1  1 = append even parity bit, sampled on an accepted load
serial_out  output  1  registered serial line, idle high
tx_busy  output  1  high from the cycle after an accepted load until frame end
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset (async, any time, including mid-frame):
  - serial_out=1, tx_busy=0, tx_done=0, state IDLE.
  - Bit counter, bit index and shift register cleared.
  - A frame in progress is aborted. No tx_done is produced for it.
- States: IDLE, START, DATA, PARITY, STOP.
- Load:
  - In IDLE, load_en=1 at a rising edge latches tx_data, bit_period and parity_en into internal registers and enters START.
  - Later changes on these inputs do not affect the frame in flight.
  - load_en while tx_busy=1 is ignored. It is not queued.
- Effective period P = latched bit_period; a value of 0 is treated as 1.
- Timing counter:
  - Counts 1..P and is enabled every cycle while not IDLE.
  - Rolls over to 1 on reaching P. That rollover advances the bit.
  - Cleared to 0 on load and on entering IDLE.
- Frame timing (load accepted at edge k):
  - Cycles k+1..k+P: serial_out=0 (start bit).
  - Data bit i (i=0..NUM_DATA_BITS-1, LSB first): cycles k+1+P*(1+i) .. k+P*(2+i).
  - PARITY (only if parity_en latched): one bit time driving the XOR of all data bits (even parity).
  - STOP: one bit time of serial_out=1.
  - Every bit lasts exactly P cycles.
- Frame length: F = P*(2+NUM_DATA_BITS+parity) cycles.
- End of frame:
  - The cycle after the final STOP cycle returns to IDLE.
  - In that cycle tx_busy=0 and tx_done=1 for exactly one cycle.
- Back-to-back: load_en=1 in the tx_done cycle is accepted. The next start bit follows the previous stop bit with zero idle cycles.
- tx_busy:
  - Rises in the cycle after the accepting edge.
  - Stays high for exactly F cycles.
- serial_out is driven from a flop only. No combinational path from inputs to serial_out.
- Simultaneous rst and load_en: reset wins.

Test Plan:
- Reset: assert rst mid-DATA of a frame (P=4, 0xA5) -> same cycle serial_out=1, tx_busy=0; no tx_done; line stays high after release until next load.
- Basic frame: P=4, parity_en=0, tx_data=0xA5 -> line 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; tx_busy high 40 cycles; tx_done single pulse at cycle 41.
- Parity: P=2, parity_en=1, tx_data=0x07 -> parity bit 1 (three ones); frame 22 cycles. Repeat with 0x03 -> parity bit 0.
- Minimum period: bit_period=0 and bit_period=1, tx_data=0xFF -> each bit exactly 1 cycle, frame 10 cycles; results identical for both values.
- Back-to-back and ignored load:
  - Pulse load_en mid-frame -> no effect on the frame.
  - load_en in the tx_done cycle with 0x3C -> start bit immediately follows the stop bit.
  - Change tx_data/bit_period during a frame -> frame unchanged.
- Long period: bit_period=16383, 0x81 -> start bit held 16383 cycles, no counter overflow; total frame 163830 cycles.
